// File: rtl/fifo_demux2.sv
// Single-entry stream demultiplexer: buffers one data word and one select bit, then routes the word to channel a or b.
// Define FIFO_DEMUX2_COUNT_EN to add per-channel transfer counters (a_count / b_count).
module fifo_demux2 #(
    parameter int INPUT_WIDTH = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INPUT_WIDTH-1:0] data,
    input  logic                   data_valid,
    output logic                   data_ready,
    input  logic                   select,
    input  logic                   select_valid,
    output logic                   select_ready,
    output logic [INPUT_WIDTH-1:0] a,
    output logic                   a_valid,
    input  logic                   a_ready,
    output logic [INPUT_WIDTH-1:0] b,
    output logic                   b_valid,
    input  logic                   b_ready
`ifdef FIFO_DEMUX2_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] a_count,
    output logic [COUNT_WIDTH-1:0] b_count
`endif
);

    // One-hot encoding leaves spare codes, which recover to IDLE with buffers cleared.
    typedef enum logic [1:0] {
        IDLE = 2'b01,
        SEND = 2'b10
    } state_t;

    state_t                 state, state_nxt;
    logic [INPUT_WIDTH-1:0] data_buf, data_buf_nxt;
    logic                   select_buf, select_buf_nxt;
    logic                   data_set, data_set_nxt;
    logic                   select_set, select_set_nxt;
    logic                   chosen_ready;

    if (INPUT_WIDTH < 1 || COUNT_WIDTH < 1) begin : g_bad_param
        $error("fifo_demux2: INPUT_WIDTH and COUNT_WIDTH must be at least 1");
    end

    assign chosen_ready = select_buf ? b_ready : a_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            data_buf   <= '0;
            select_buf <= 1'b0;
            data_set   <= 1'b0;
            select_set <= 1'b0;
        end else begin
            state      <= state_nxt;
            data_buf   <= data_buf_nxt;
            select_buf <= select_buf_nxt;
            data_set   <= data_set_nxt;
            select_set <= select_set_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        data_buf_nxt   = data_buf;
        select_buf_nxt = select_buf;
        data_set_nxt   = data_set;
        select_set_nxt = select_set;
        case (state)
            IDLE: begin
                // Routing decision uses the pre-edge flags, so a word captured this edge waits one more cycle.
                if (data_set && select_set) begin
                    state_nxt = SEND;
                end
                if (!data_set && data_valid) begin
                    data_buf_nxt = data;
                    data_set_nxt = 1'b1;
                end
                if (!select_set && select_valid) begin
                    select_buf_nxt = select;
                    select_set_nxt = 1'b1;
                end
            end
            SEND: begin
                if (chosen_ready) begin
                    state_nxt      = IDLE;
                    data_buf_nxt   = '0;
                    select_buf_nxt = 1'b0;
                    data_set_nxt   = 1'b0;
                    select_set_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt      = IDLE;
                data_buf_nxt   = '0;
                select_buf_nxt = 1'b0;
                data_set_nxt   = 1'b0;
                select_set_nxt = 1'b0;
            end
        endcase
    end

    assign data_ready   = !data_set;
    assign select_ready = !select_set;
    assign a            = data_buf;
    assign b            = data_buf;
    assign a_valid      = (state == SEND) && !select_buf;
    assign b_valid      = (state == SEND) && select_buf;

`ifdef FIFO_DEMUX2_COUNT_EN
    logic xfer_a, xfer_b;

    assign xfer_a = a_valid && a_ready;
    assign xfer_b = b_valid && b_ready;

    // Counters wrap naturally at 2^COUNT_WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (xfer_a) begin
                a_count <= a_count + COUNT_WIDTH'(1);
            end
            if (xfer_b) begin
                b_count <= b_count + COUNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: doc/fifo_demux2.md
FIFO_DEMUX2 -- requirements
Module: fifo_demux2

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 32, data path width in bits.
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, transfer counter width (used only with FIFO_DEMUX2_COUNT_EN).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports data / data_valid / data_ready  input / input / output  INPUT_WIDTH / 1 / 1  source word stream.
REQ-006 SHALL have ports select / select_valid / select_ready  input / input / output  1 / 1 / 1  routing stream (0 = a, 1 = b).
REQ-007 SHALL have ports a / a_valid / a_ready  output / output / input  INPUT_WIDTH / 1 / 1  output channel a.
REQ-008 SHALL have ports b / b_valid / b_ready  output / output / input  INPUT_WIDTH / 1 / 1  output channel b.
REQ-009 SHALL have, only with FIFO_DEMUX2_COUNT_EN, ports a_count and b_count  output  COUNT_WIDTH  completed transfers per channel.

Function
REQ-010 SHALL hold one data word and one select bit in internal buffers, each with a set flag.
REQ-011 SHALL drive data_ready = !data_set and select_ready = !select_set, combinationally from the registered flags.
REQ-012 SHALL implement two states, IDLE and SEND; any illegal encoding returns to IDLE with buffers and flags cleared.
REQ-013 In IDLE, SHALL capture data and set data_set on an edge where !data_set && data_valid; likewise select/select_set.
REQ-014 In IDLE, SHALL move to SEND on an edge where data_set and select_set are both already 1 (pre-edge values).
REQ-015 Latency: both handshakes at edge N -> SEND after edge N+1 -> output valid during the cycle following N+1.
REQ-016 SHALL drive a and b both from the data buffer at all times.
REQ-017 SHALL drive a_valid = (state == SEND) && !select_buffer, and b_valid = (state == SEND) && select_buffer; never both.
REQ-018 In SEND, on an edge where the selected channel's ready is 1, SHALL clear the data buffer, select buffer and both flags to 0 and return to IDLE.
REQ-019 In SEND with the selected ready low, SHALL hold all state; output data and valid stable until accepted.
REQ-020 SHALL ignore ready of the non-selected channel in all states.
REQ-021 Data and select streams SHALL be accepted independently; one may arrive arbitrarily earlier and wait with its flag set.
REQ-022 Data/select valid asserted while the corresponding flag is set SHALL be stalled (not captured, not dropped).
REQ-023 Maximum throughput SHALL be one routed word per three cycles.

Reset
REQ-024 Asserting rst SHALL immediately, without waiting for clk, set state = IDLE, buffers = 0, flags = 0.
REQ-025 During reset outputs SHALL be: data_ready = 1, select_ready = 1, a_valid = 0, b_valid = 0, a = b = 0, counters = 0.
REQ-026 Reset mid-transfer (IDLE with a flag set, or SEND) SHALL discard the pending word with no output handshake.

Configuration
REQ-027 Macro FIFO_DEMUX2_COUNT_EN SHALL compile in a_count/b_count ports and counters.
REQ-028 With the macro, each counter SHALL increment by 1 on the edge its channel completes a transfer (REQ-018), wrapping 2^COUNT_WIDTH-1 -> 0.
REQ-029 Without the macro, the count ports and all counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Route to a: data=0x0000_00AA and select=0 together at edge 0, a_ready=1 -> a_valid=1 with a=0x0000_00AA in cycle after edge 1, b_valid=0 throughout, IDLE after edge 2.
REQ-031 Route to b with stall: select=1, data=0x1234_5678, b_ready=0 for 5 cycles -> b_valid held 1 and b=0x1234_5678 stable, data_ready=0, a_ready toggling has no effect; b_ready=1 -> one transfer.
REQ-032 Skewed arrival: select=0 accepted, data withheld 4 cycles -> select_ready=0, no valid output; data=0x5 arrives -> a_valid 2 edges later, a=0x5.
REQ-033 Back-pressure inputs: second data=0x7 offered while first word pending -> data_ready=0, 0x7 captured only after first transfer completes, then routed per its own select.
REQ-034 Async reset in SEND: assert rst between edges -> a_valid/b_valid fall immediately, data_ready=select_ready=1, no transfer recorded.
REQ-035 With FIFO_DEMUX2_COUNT_EN, COUNT_WIDTH=2: five transfers to a, two to b -> a_count=1 (wrapped), b_count=2.
